knn_burst_sequencer: RTL and testbench

KNN_BURST_SEQUENCER -- requirements
Module: knn_burst_sequencer

---
 rtl/knn_burst_sequencer.sv | 169 ++++++++++++++++
 tb/tb_knn_burst_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_burst_sequencer.sv
// Burst/sample sequencer for a k-NN engine: walks L training samples in bursts of
// up to MAX_ELEMENTS elements, then hands off to the voting unit.
module knn_burst_sequencer #(
    parameter int M            = 50,
    parameter int N            = 10,
    parameter int MAX_ELEMENTS = 32,
    parameter int L            = 64,
    localparam int TOTAL = M * N,
    localparam int NB    = (TOTAL + MAX_ELEMENTS - 1) / MAX_ELEMENTS,
    localparam int LAST  = TOTAL - (NB - 1) * MAX_ELEMENTS,
    localparam int BW    = $clog2(NB + 1),
    localparam int LW    = $clog2(MAX_ELEMENTS + 1),
    localparam int SW    = $clog2(L + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          read_done,
    input  logic          calc_ack,
    input  logic          vote_done,
    output logic          data_request,
    output logic          calc_start,
    output logic [BW-1:0] burst_idx,
    output logic [LW-1:0] burst_len,
    output logic [SW-1:0] sample_idx,
    output logic          done,
    output logic          vote_start,
    output logic          inference_done,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CALC,
        S_WAIT_CALC,
        S_SAMPLE,
        S_VOTE,
        S_WAIT_VOTE,
        S_FIN
    } state_t;

    localparam logic [BW-1:0] LAST_BURST  = BW'(NB - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(L - 1);
    localparam logic [LW-1:0] FULL_LEN    = LW'(MAX_ELEMENTS);
    localparam logic [LW-1:0] LAST_LEN    = LW'(LAST);

    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   burst_d;
    logic [SW-1:0]   sample_d;
    logic [LW-1:0]   burst_len_d;
    logic            data_request_d;
    logic            calc_start_d;
    logic            done_d;
    logic            vote_start_d;
    logic            inference_done_d;
    logic            busy_d;

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every comb output is defaulted first so no path can infer a latch.
        state_d  = state_q;
        burst_d  = burst_idx;
        sample_d = sample_idx;

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            burst_d  = '0;
            sample_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_REQ;
                        burst_d  = '0;
                        sample_d = '0;
                    end
                end
                S_REQ: begin
                    if (read_done) state_d = S_CALC;
                end
                S_CALC: begin
                    state_d = S_WAIT_CALC;
                end
                S_WAIT_CALC: begin
                    if (calc_ack) begin
                        if (burst_idx == LAST_BURST) begin
                            state_d = S_SAMPLE;
                            burst_d = '0;
                        end else begin
                            state_d = S_REQ;
                            burst_d = burst_idx + 1'b1;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (sample_idx == LAST_SAMPLE) begin
                        state_d = S_VOTE;
                    end else begin
                        state_d  = S_REQ;
                        sample_d = sample_idx + 1'b1;
                    end
                end
                S_VOTE: begin
                    state_d = S_WAIT_VOTE;
                end
                S_WAIT_VOTE: begin
                    if (vote_done) state_d = S_FIN;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    burst_d  = '0;
                    sample_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and then registered, so each output
    // reflects the state the FSM occupies during that cycle.
    always_comb begin
        data_request_d   = (state_d == S_REQ);
        calc_start_d     = (state_d == S_CALC);
        done_d           = (state_d == S_SAMPLE);
        vote_start_d     = (state_d == S_VOTE);
        inference_done_d = (state_d == S_FIN);
        busy_d           = (state_d != S_IDLE);
        if (state_d == S_IDLE) begin
            burst_len_d = '0;
        end else if (burst_d == LAST_BURST) begin
            burst_len_d = LAST_LEN;
        end else begin
            burst_len_d = FULL_LEN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            burst_idx      <= '0;
            sample_idx     <= '0;
            burst_len      <= '0;
            data_request   <= 1'b0;
            calc_start     <= 1'b0;
            done           <= 1'b0;
            vote_start     <= 1'b0;
            inference_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            burst_idx      <= burst_d;
            sample_idx     <= sample_d;
            burst_len      <= burst_len_d;
            data_request   <= data_request_d;
            calc_start     <= calc_start_d;
            done           <= done_d;
            vote_start     <= vote_start_d;
            inference_done <= inference_done_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_knn_burst_sequencer.sv
// Scoreboard bench for knn_burst_sequencer: stimulus pushes expected pulses,
// a negedge monitor pops and compares them; a second instance covers NB=1.
module tb_knn_burst_sequencer;

    localparam int A_NB   = 16;  // 500 elements / 32 per burst
    localparam int A_LAST = 20;  // 500 - 15*32
    localparam int A_L    = 64;
    localparam int B_L    = 4;

    typedef enum int {EV_CALC, EV_DONE, EV_VOTE, EV_FIN} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       burst;
        int       len;
        int       sample;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, read_done = 1'b0, calc_ack = 1'b0, vote_done = 1'b0;
    logic       data_request, calc_start, done, vote_start, inference_done, busy;
    logic [4:0] burst_idx;
    logic [5:0] burst_len;
    logic [6:0] sample_idx;

    logic b_start = 1'b0, b_abort = 1'b0, b_read_done = 1'b0, b_calc_ack = 1'b0, b_vote_done = 1'b0;
    logic       b_data_request, b_calc_start, b_done, b_vote_start, b_inference_done, b_busy;
    logic [0:0] b_burst_idx;
    logic [5:0] b_burst_len;
    logic [2:0] b_sample_idx;
    int         b_rises = 0;
    logic       b_req_prev = 1'b0;

    always #5 clk = ~clk;

    knn_burst_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .read_done(read_done),
        .calc_ack(calc_ack), .vote_done(vote_done), .data_request(data_request),
        .calc_start(calc_start), .burst_idx(burst_idx), .burst_len(burst_len),
        .sample_idx(sample_idx), .done(done), .vote_start(vote_start),
        .inference_done(inference_done), .busy(busy)
    );

    knn_burst_sequencer #(.M(2), .N(10), .MAX_ELEMENTS(32), .L(B_L)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .read_done(b_read_done),
        .calc_ack(b_calc_ack), .vote_done(b_vote_done), .data_request(b_data_request),
        .calc_start(b_calc_start), .burst_idx(b_burst_idx), .burst_len(b_burst_len),
        .sample_idx(b_sample_idx), .done(b_done), .vote_start(b_vote_start),
        .inference_done(b_inference_done), .busy(b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input int b, input int len, input int s);
        ev_t e;
        e.kind = k; e.burst = b; e.len = len; e.sample = s;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'(k), -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_sample_idx", int'(sample_idx), e.sample);
            if (k == EV_CALC) begin
                check("calc_burst_idx", int'(burst_idx), e.burst);
                check("calc_burst_len", int'(burst_len), e.len);
            end
        end
    endtask

    // Scoreboard monitor for the default-parameter instance.
    always @(negedge clk) begin
        if (rst) begin
            if (calc_start)     observe(EV_CALC);
            if (done)           observe(EV_DONE);
            if (vote_start)     observe(EV_VOTE);
            if (inference_done) observe(EV_FIN);
        end
    end

    always @(negedge clk) begin
        if (b_data_request && !b_req_prev) b_rises++;
        b_req_prev <= b_data_request;
    end

    function automatic bit sig(input int id);
        case (id)
            0: return data_request;
            1: return vote_start;
            2: return inference_done;
            3: return b_data_request;
            4: return b_calc_start;
            5: return b_done;
            6: return b_vote_start;
            7: return b_inference_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int id, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sig(id)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({"timeout_", name}, 0, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_data_request"}, int'(data_request), 0);
        check({tag, "_burst_idx"}, int'(burst_idx), 0);
        check({tag, "_sample_idx"}, int'(sample_idx), 0);
        check({tag, "_burst_len"}, int'(burst_len), 0);
    endtask

    // One inference on dut_a; abort/reset/glitch injected at the given (sample, burst).
    task automatic run_a(input int abort_s, input int abort_b, input int rst_s, input int rst_b,
                         input int glitch_s, input int glitch_b);
        bit ok;
        bit glitch;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int s = 0; s < A_L; s++) begin
            for (int b = 0; b < A_NB; b++) begin
                wait_for(0, "data_request", ok);
                if (!ok) return;
                check("req_burst_idx", int'(burst_idx), b);
                check("req_sample_idx", int'(sample_idx), s);
                if (s == abort_s && b == abort_b) begin
                    @(posedge clk); #1 abort = 1'b1;
                    @(posedge clk); #1 abort = 1'b0;
                    @(negedge clk);
                    check_idle("after_abort");
                    repeat (10) @(negedge clk);
                    check("abort_stays_idle", int'(busy), 0);
                    return;
                end
                glitch = (s == glitch_s && b == glitch_b);
                repeat (2) @(posedge clk);
                #1 read_done = 1'b1;
                push(EV_CALC, b, (b == A_NB - 1) ? A_LAST : 32, s);
                @(posedge clk); #1 read_done = glitch; start = glitch;
                @(posedge clk); #1 start = 1'b0;
                @(posedge clk);
                if (s == rst_s && b == rst_b) begin
                    #3 rst = 1'b0;
                    #1;
                    check_idle("async_reset");
                    check("async_reset_calc_start", int'(calc_start), 0);
                    check("async_reset_done", int'(done), 0);
                    @(posedge clk); #2 rst = 1'b1;
                    read_done = 1'b0;
                    return;
                end
                #1 calc_ack = 1'b1;
                if (b == A_NB - 1) begin
                    push(EV_DONE, 0, 0, s);
                    if (s == A_L - 1) push(EV_VOTE, 0, 0, s);
                end
                @(posedge clk); #1 calc_ack = 1'b0; read_done = 1'b0;
            end
        end
        wait_for(1, "vote_start", ok);
        if (!ok) return;
        @(posedge clk); #1 vote_done = 1'b1;
        push(EV_FIN, 0, 0, A_L - 1);
        @(posedge clk); #1 vote_done = 1'b0;
        wait_for(2, "inference_done", ok);
        if (!ok) return;
        @(negedge clk);
        check("fin_busy", int'(busy), 0);
        check("fin_sample_idx_hold", int'(sample_idx), A_L - 1);
    endtask

    task automatic run_b();
        bit ok;
        b_rises = 0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int s = 0; s < B_L; s++) begin
            wait_for(3, "b_data_request", ok);
            if (!ok) return;
            check("b_burst_len", int'(b_burst_len), 20);
            check("b_burst_idx", int'(b_burst_idx), 0);
            check("b_sample_idx", int'(b_sample_idx), s);
            @(posedge clk); #1 b_read_done = 1'b1;
            @(posedge clk); #1 b_read_done = 1'b0;
            wait_for(4, "b_calc_start", ok);
            if (!ok) return;
            @(posedge clk); #1 b_calc_ack = 1'b1;
            @(posedge clk); #1 b_calc_ack = 1'b0;
            wait_for(5, "b_done", ok);
            if (!ok) return;
        end
        wait_for(6, "b_vote_start", ok);
        if (!ok) return;
        @(posedge clk); #1 b_vote_done = 1'b1;
        @(posedge clk); #1 b_vote_done = 1'b0;
        wait_for(7, "b_inference_done", ok);
        if (!ok) return;
        check("b_request_phases", b_rises, B_L);
    endtask

    initial begin
        #1;
        check_idle("reset");
        check("reset_inference_done", int'(inference_done), 0);
        #22 rst = 1'b1;

        run_a(-1, -1, -1, -1, -1, -1);
        check("queue_drained_full", exp_q.size(), 0);

        run_a(10, 5, -1, -1, -1, -1);
        check("queue_drained_abort", exp_q.size(), 0);

        run_a(-1, -1, -1, -1, 3, 2);
        check("queue_drained_glitch", exp_q.size(), 0);

        run_a(-1, -1, 2, 7, -1, -1);
        check("queue_drained_reset", exp_q.size(), 0);

        run_a(-1, -1, -1, -1, -1, -1);
        check("queue_drained_after_reset", exp_q.size(), 0);

        run_b();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got %0d expected %0d", 0, 1);
        $fatal(1, "watchdog expired");
    end

endmodule
